// File: rtl/kuz_pkg.sv
// Shared Kuznyechik definitions: GF(2^8) multiply over 0x1C3, l() coefficients, FSM state type.
package kuz_pkg;

  localparam logic [7:0] GF_POLY = 8'hC3;

  // Coefficient order matches byte order a15 .. a0.
  localparam logic [7:0] LIN_COEF [0:15] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} l_state_t;

  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    // NOTE: blocking assignments are correct here; p and x are loop temporaries, not state.
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/l_convertion_iter_if.sv
// Input/output valid-ready stream of the iterative L stage; mode_inv exists only with KUZ_L_INVERSE_EN.
interface l_convertion_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef KUZ_L_INVERSE_EN
  logic         mode_inv;
`endif

  modport master (
    output in_valid, in_data, out_ready,
`ifdef KUZ_L_INVERSE_EN
    output mode_inv,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef KUZ_L_INVERSE_EN
    input  mode_inv,
`endif
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/l_linear_comb.sv
// Combinational Kuznyechik l(): 16 input bytes (a15 at [127:120]) folded into one GF(2^8) byte.
module l_linear_comb
  import kuz_pkg::*;
(
  input  logic [127:0] a,
  output logic [7:0]   y
);

  always_comb begin
    // NOTE: default first so every path assigns y and no latch is inferred.
    y = 8'h00;
    for (int i = 0; i < 16; i++) begin
      y = y ^ gf_mul8(a[127 - 8*i -: 8], LIN_COEF[i]);
    end
  end

endmodule

// File: rtl/l_convertion_iter.sv
// Iterative Kuznyechik L = R^ROUNDS, one R step per clock, valid/ready on both sides.
// Define KUZ_L_INVERSE_EN to add mode_inv and the R^-1 datapath.
module l_convertion_iter
  import kuz_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  l_convertion_iter_if.slave bus
);

  localparam int              CW   = $clog2(ROUNDS) + 1;
  localparam logic [CW-1:0]   LAST = CW'(ROUNDS - 1);

  l_state_t       state;
  logic [127:0]   st;
  logic [CW-1:0]  cnt;
  logic [127:0]   lin_in;
  logic [7:0]     l_byte;
  logic [127:0]   next_st;

`ifdef KUZ_L_INVERSE_EN
  logic mode;

  // Inverse step evaluates l() over a14..a0 followed by the outgoing a15.
  assign lin_in  = mode ? {st[119:0], st[127:120]} : st;
  assign next_st = mode ? {st[119:0], l_byte} : {l_byte, st[127:8]};
`else
  assign lin_in  = st;
  assign next_st = {l_byte, st[127:8]};
`endif

  l_linear_comb u_lin (
    .a (lin_in),
    .y (l_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so out_data reads zero during and after reset.
      state <= IDLE;
      st    <= '0;
      cnt   <= '0;
`ifdef KUZ_L_INVERSE_EN
      mode  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            st    <= bus.in_data;
            cnt   <= '0;
`ifdef KUZ_L_INVERSE_EN
            mode  <= bus.mode_inv;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          st  <= next_st;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs depend on the state register only.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = st;

endmodule
